// File: rtl/sdp_ram_rdq.sv
// Read-side stage for a simple-dual-port RAM: issues port-B reads, tracks the
// fixed read latency and queues returned words behind a valid/ready output.
module sdp_ram_rdq #(
  parameter int ADR  = 11,
  parameter int WID  = 72,
  parameter int NCLK = 2,
  parameter int DEPQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic [ADR-1:0]              req_adr,
  output logic [ADR-1:0]              ram_adr,
  output logic                        ram_ren,
  input  logic [WID-1:0]              ram_rda,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [WID-1:0]              out_dat,
  output logic [$clog2(DEPQ+1)-1:0]   lvl
);

  localparam int LW = $clog2(DEPQ + 1);
  localparam int PW = (DEPQ > 1) ? $clog2(DEPQ) : 1;

  logic [LW-1:0]   lvl_q;
  logic [LW-1:0]   cnt_q;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [NCLK-1:0] vld_pipe;
  logic [WID-1:0]  mem [DEPQ];

  logic issue;
  logic pop;
  logic cap;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover words in flight as well as queued ones, so the queue can
  // never be written while full.
  assign req_rdy = rst_n & (lvl_q < LW'(DEPQ));
  assign issue   = req_vld & req_rdy;
  assign ram_ren = issue;
  assign ram_adr = req_adr;

  assign out_vld = rst_n & (cnt_q != '0);
  assign pop     = out_vld & out_rdy;
  assign out_dat = mem[rd_ptr];
  assign lvl     = rst_n ? lvl_q : '0;

  // The oldest stage marks the cycle in which ram_rda carries the word.
  assign cap = vld_pipe[NCLK-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q    <= '0;
      cnt_q    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      vld_pipe <= '0;
    end else begin
      lvl_q    <= lvl_q + LW'(issue) - LW'(pop);
      cnt_q    <= cnt_q + LW'(cap) - LW'(pop);
      vld_pipe <= NCLK'({vld_pipe, issue});
      if (cap) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // NOTE: the storage array has no reset; out_dat is only meaningful while
  // out_vld is high, and the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= ram_rda;
  end

endmodule

// File: doc/sdp_ram_rdq.md
SDP_RAM_RDQ -- requirements
Module: sdp_ram_rdq

Purpose: read-side stage for the simple-dual-port RAM. It issues port-B reads, tracks the fixed read latency, and buffers the returned words behind a valid/ready output with credit-based flow control.

Interface
Parameters:
REQ-001 SHALL have parameter ADR, default 11: read address width.
REQ-002 SHALL have parameter WID, default 72: data width.
REQ-003 SHALL have parameter NCLK, default 2: RAM read latency in clocks, from the cycle ram_ren is high to the cycle ram_rda is valid; legal range 1..4.
REQ-004 SHALL have parameter DEPQ, default 4: output queue depth; legal when DEPQ >= NCLK+1.

Ports:
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port req_vld, input, 1: read request valid.
REQ-008 SHALL have port req_rdy, output, 1: request accepted when high with req_vld.
REQ-009 SHALL have port req_adr, input, ADR: request address.
REQ-010 SHALL have port ram_adr, output, ADR: to RAM port-B address.
REQ-011 SHALL have port ram_ren, output, 1: to RAM port-B read enable.
REQ-012 SHALL have port ram_rda, input, WID: RAM port-B read data.
REQ-013 SHALL have port out_vld, output, 1: output word valid.
REQ-014 SHALL have port out_rdy, input, 1: downstream ready.
REQ-015 SHALL have port out_dat, output, WID: output word.
REQ-016 SHALL have port lvl, output, clog2(DEPQ+1): credits in use (in flight plus queued).

Function
REQ-017 SHALL define issue = req_vld & req_rdy and pop = out_vld & out_rdy.
REQ-018 SHALL drive req_rdy = rst_n & (lvl < DEPQ), combinationally.
REQ-019 SHALL drive ram_ren = issue and ram_adr = req_adr, both combinationally; no other RAM read SHALL occur.
REQ-020 SHALL shift issue through an NCLK-stage valid pipeline; a word is captured from ram_rda on the edge ending the cycle that is NCLK cycles after issue.
REQ-021 SHALL write captured words into a DEPQ-entry circular FIFO with independent read and write pointers that wrap from DEPQ-1 to 0.
REQ-022 SHALL make out_vld high exactly when the FIFO is non-empty, with out_dat equal to the head entry.
- Latency: issue in cycle t gives out_vld in cycle t+NCLK+1.
REQ-023 SHALL update lvl_next = lvl + issue - pop; simultaneous issue and pop SHALL leave lvl unchanged.
REQ-024 SHALL preserve request order and SHALL never drop or duplicate a word.
REQ-025 SHALL hold out_dat stable while out_vld=1 and out_rdy=0.
REQ-026 SHALL let a capture and a pop in the same cycle on a FIFO holding one entry update the head to the new word and keep out_vld high, with no bubble.
REQ-027 SHALL guarantee no FIFO overflow, because credits bound in-flight plus queued words to DEPQ; a write to a full FIFO is a design error that the bench SHALL check.
REQ-028 SHALL sustain one word per clock indefinitely when out_rdy=1 and DEPQ >= NCLK+1.
REQ-029 SHALL stall with out_rdy=0 and lvl=DEPQ by holding req_rdy low; req_rdy SHALL rise in the cycle after the first pop.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, clear the pointers, lvl and the valid pipeline.
- Outputs during reset: req_rdy=0, ram_ren=0, out_vld=0, lvl=0.
- out_dat is don't-care while out_vld=0; FIFO storage is not reset.
REQ-031 SHALL discard reads in flight at reset; RAM data returning after reset deasserts SHALL NOT be captured.
REQ-032 SHALL allow req_rdy=1 in the first cycle after rst_n rises.

Verification
REQ-033 Single read: RAM model with NCLK=2 returns 72'hA5 for adr 5; one request for adr 5 at cycle 10 -> ram_ren=1 with ram_adr=5 at cycle 10; out_vld=1 with out_dat=72'hA5 at cycle 13; lvl returns to 0 after the pop.
REQ-034 Streaming: 100 back-to-back requests, adr 0..99, out_rdy=1 -> req_rdy never low; 100 words in order; one word per clock after a 3-cycle fill.
REQ-035 Backpressure: out_rdy=0 and req_vld=1 -> exactly 4 issues, then req_rdy=0 with lvl=4; out_rdy=1 -> words 0..3 delivered, issues resume, no loss.
REQ-036 Simultaneous: at lvl=3, issue and pop in the same cycle -> lvl stays 3; 1-entry FIFO with capture and pop together -> out_vld stays 1 with the new data.
REQ-037 Reset mid-flight: 2 reads in flight and 1 queued, rst_n=0 for 1 cycle -> out_vld=0 and lvl=0 afterwards; late ram_rda ignored; the next request returns correct data.
REQ-038 Randomised: random req_vld/out_rdy, 10k requests -> scoreboard matches every word in order; lvl <= DEPQ always; no FIFO overflow assertion fires.
